// File: rtl/tbl_ctr_pkg.sv
// rtl/tbl_ctr_pkg.sv - shared constants and types for the predictor counter table controller
// Purpose: table geometry, counter limits, lane/entry types and the controller FSM state type.
package tbl_ctr_pkg;

  localparam int DEPTH   = 2048;
  localparam int IDX_W   = 11;
  localparam int LANES   = 4;
  localparam int CTR_W   = 3;
  localparam int ENTRY_W = LANES * CTR_W;

  typedef logic signed [CTR_W-1:0] ctr_t;
  // Lane i occupies bits [i*CTR_W +: CTR_W] of an entry.
  typedef ctr_t [LANES-1:0] entry_t;

  localparam ctr_t CTR_MAX = ctr_t'(3);
  localparam ctr_t CTR_MIN = ctr_t'(-4);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/tbl_sat_lane.sv
// rtl/tbl_sat_lane.sv - single-lane signed saturating increment/decrement
// Purpose: computes the new value of one counter lane.
// Ports:
//   i_old - current lane value (signed)
//   i_en  - lane selected for update; when low the lane passes through unchanged
//   i_inc - 1 = increment toward CTR_MAX, 0 = decrement toward CTR_MIN
//   o_new - updated lane value
module tbl_sat_lane import tbl_ctr_pkg::*; (
  input  ctr_t i_old,
  input  logic i_en,
  input  logic i_inc,
  output ctr_t o_new
);

  always_comb begin
    o_new = i_old;
    if (i_en) begin
      if (i_inc) begin
        if (i_old != CTR_MAX) o_new = i_old + ctr_t'(1);
      end else begin
        if (i_old != CTR_MIN) o_new = i_old - ctr_t'(1);
      end
    end
  end

endmodule

// File: rtl/tbl_ctr_update_ctrl.sv
// rtl/tbl_ctr_update_ctrl.sv - init sweep, prediction read and counter RMW controller for the 2048x12 table
// Purpose: owns the read and write ports of the counter array. After reset it zeroes every
// entry, then serves prediction reads (priority) and two-stage read-modify-write updates.
// Ports:
//   clock, reset                       - clock and synchronous active-high reset
//   pred_req_valid/ready/idx           - prediction read request
//   pred_resp_valid/data               - prediction response, one cycle after acceptance
//   upd_valid/ready/idx/mask/dir       - counter update request
//   init_busy                          - init sweep in progress
//   mem_r_en/addr, mem_r_data          - array read port (data valid the cycle after mem_r_en)
//   mem_w_en/addr/data                 - array write port
module tbl_ctr_update_ctrl import tbl_ctr_pkg::*; (
  input  logic               clock,
  input  logic               reset,
  input  logic               pred_req_valid,
  output logic               pred_req_ready,
  input  logic [IDX_W-1:0]   pred_req_idx,
  output logic               pred_resp_valid,
  output logic [ENTRY_W-1:0] pred_resp_data,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [IDX_W-1:0]   upd_idx,
  input  logic [LANES-1:0]   upd_mask,
  input  logic [LANES-1:0]   upd_dir,
  output logic               init_busy,
  output logic               mem_r_en,
  output logic [IDX_W-1:0]   mem_r_addr,
  input  logic [ENTRY_W-1:0] mem_r_data,
  output logic               mem_w_en,
  output logic [IDX_W-1:0]   mem_w_addr,
  output logic [ENTRY_W-1:0] mem_w_data
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_sweep_cnt;
  logic               r_pred_resp_valid;
  logic               r_s1_valid;
  logic [IDX_W-1:0]   r_s1_idx;
  logic [LANES-1:0]   r_s1_mask;
  logic [LANES-1:0]   r_s1_dir;

  logic               w_init;
  logic               w_run;
  logic               w_pred_acc;
  logic               w_upd_acc;
  logic               w_s1_wr;
  entry_t             w_old_entry;
  entry_t             w_new_entry;

  // Reset is synchronous, so every control output is also gated by reset to hold the
  // quiescent values during the reset cycle itself (and to drop an in-flight S1 write).
  assign w_init = (r_state == ST_INIT) && !reset;
  assign w_run  = (r_state == ST_RUN) && !reset;

  assign pred_req_ready = w_run;
  assign upd_ready      = w_run && !pred_req_valid;
  assign w_pred_acc     = pred_req_valid && pred_req_ready;
  assign w_upd_acc      = upd_valid && upd_ready;
  assign init_busy      = reset || (r_state == ST_INIT);

  assign mem_r_en   = w_pred_acc || w_upd_acc;
  assign mem_r_addr = w_pred_acc ? pred_req_idx : upd_idx;

  assign pred_resp_valid = r_pred_resp_valid && !reset;
  assign pred_resp_data  = mem_r_data;

  // S1 reads the entry fetched by the S0 read. A same-index write landing on the S0 edge is
  // already visible here because the array registers the read address on that same edge.
  assign w_old_entry = entry_t'(mem_r_data);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    tbl_sat_lane u_lane (
      .i_old (w_old_entry[g]),
      .i_en  (r_s1_mask[g]),
      .i_inc (r_s1_dir[g]),
      .o_new (w_new_entry[g])
    );
  end

  // Update requests are never accepted in INIT, so the sweep and S1 never share the port.
  assign w_s1_wr    = w_run && r_s1_valid;
  assign mem_w_en   = w_init || w_s1_wr;
  assign mem_w_addr = w_init ? r_sweep_cnt : r_s1_idx;
  assign mem_w_data = w_init ? '0 : w_new_entry;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state           <= ST_INIT;
      r_sweep_cnt       <= '0;
      r_pred_resp_valid <= 1'b0;
      r_s1_valid        <= 1'b0;
    end else begin
      r_pred_resp_valid <= w_pred_acc;
      r_s1_valid        <= w_upd_acc;
      if (w_upd_acc) begin
        r_s1_idx  <= upd_idx;
        r_s1_mask <= upd_mask;
        r_s1_dir  <= upd_dir;
      end
      case (r_state)
        ST_INIT: begin
          r_sweep_cnt <= r_sweep_cnt + 1'b1;
          if (r_sweep_cnt == IDX_W'(DEPTH - 1)) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_tbl_ctr_update_ctrl.sv
// tb/tb_tbl_ctr_update_ctrl.sv - self-checking bench for tbl_ctr_update_ctrl with an array model
module tb_tbl_ctr_update_ctrl;
  import tbl_ctr_pkg::*;

  logic               clock;
  logic               reset;
  logic               pred_req_valid;
  logic               pred_req_ready;
  logic [IDX_W-1:0]   pred_req_idx;
  logic               pred_resp_valid;
  logic [ENTRY_W-1:0] pred_resp_data;
  logic               upd_valid;
  logic               upd_ready;
  logic [IDX_W-1:0]   upd_idx;
  logic [LANES-1:0]   upd_mask;
  logic [LANES-1:0]   upd_dir;
  logic               init_busy;
  logic               mem_r_en;
  logic [IDX_W-1:0]   mem_r_addr;
  logic [ENTRY_W-1:0] mem_r_data;
  logic               mem_w_en;
  logic [IDX_W-1:0]   mem_w_addr;
  logic [ENTRY_W-1:0] mem_w_data;

  tbl_ctr_update_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .pred_req_valid  (pred_req_valid),
    .pred_req_ready  (pred_req_ready),
    .pred_req_idx    (pred_req_idx),
    .pred_resp_valid (pred_resp_valid),
    .pred_resp_data  (pred_resp_data),
    .upd_valid       (upd_valid),
    .upd_ready       (upd_ready),
    .upd_idx         (upd_idx),
    .upd_mask        (upd_mask),
    .upd_dir         (upd_dir),
    .init_busy       (init_busy),
    .mem_r_en        (mem_r_en),
    .mem_r_addr      (mem_r_addr),
    .mem_r_data      (mem_r_data),
    .mem_w_en        (mem_w_en),
    .mem_w_addr      (mem_w_addr),
    .mem_w_data      (mem_w_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Array macro: registered read address, write at the same edge, so a read issued on the
  // write edge returns the freshly written data.
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]   mem_raddr_q;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] <= 12'hABC;
    mem_raddr_q <= '0;
  end

  always @(posedge clock) begin
    if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
    if (mem_r_en) mem_raddr_q <= mem_r_addr;
  end
  assign mem_r_data = mem[mem_raddr_q];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference table contents and saturating update written lane by lane as integers.
  logic [ENTRY_W-1:0] model [DEPTH];

  function automatic logic [ENTRY_W-1:0] sat_upd(input logic [ENTRY_W-1:0] old,
                                                 input logic [3:0] m, input logic [3:0] d);
    logic [ENTRY_W-1:0] res;
    logic signed [2:0]  s;
    int                 v;
    res = old;
    for (int l = 0; l < 4; l++) begin
      s = old[l*3 +: 3];
      v = s;
      if (m[l]) begin
        v = d[l] ? v + 1 : v - 1;
        if (v > 3) v = 3;
        if (v < -4) v = -4;
      end
      res[l*3 +: 3] = v[2:0];
    end
    return res;
  endfunction

  // Scoreboard of expected prediction responses.
  logic [ENTRY_W-1:0] sb [$];

  always @(negedge clock) begin
    if (pred_resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pred_resp", 1, 0);
      end else begin
        chk("pred_resp_data", pred_resp_data, sb.pop_front());
      end
    end
  end

  typedef struct {
    bit                 is_pred;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         mask;
    logic [3:0]         dir;
    logic [ENTRY_W-1:0] exp;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input bit p, input int idx, input logic [3:0] m,
                              input logic [3:0] d, input logic [11:0] e);
    vec_t v;
    v.is_pred = p;
    v.idx     = IDX_W'(idx);
    v.mask    = m;
    v.dir     = d;
    v.exp     = e;
    tbl.push_back(v);
  endfunction

  task automatic idle_inputs();
    pred_req_valid = 1'b0;
    upd_valid      = 1'b0;
  endtask

  // Expects the sweep to start on the next negedge; holds both requests high to prove they
  // are refused throughout, and drops them before RUN begins.
  task automatic check_sweep(input string tag);
    int bad;
    int first_bad;
    bad = 0;
    first_bad = -1;
    pred_req_valid = 1'b1;
    upd_valid      = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      if (!(init_busy === 1'b1 && mem_w_en === 1'b1 && mem_w_addr === i[IDX_W-1:0] &&
            mem_w_data === '0 && pred_req_ready === 1'b0 && upd_ready === 1'b0 &&
            mem_r_en === 1'b0)) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
      if (i == DEPTH - 1) idle_inputs();
    end
    chk({tag, "_bad_cycles"}, bad, 0);
    if (first_bad >= 0) $display("  first bad sweep cycle %0d", first_bad);
    @(negedge clock);
    chk({tag, "_busy_after"}, init_busy, 0);
    chk({tag, "_ready_after"}, pred_req_ready, 1);
    chk({tag, "_no_write_after"}, mem_w_en, 0);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clock);
    chk({tag, "_sb_drain"}, sb.size(), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          op;
    int          found;
    logic [10:0] ix;
    logic [3:0]  rm;
    logic [3:0]  rd;

    reset = 1'b1;
    idle_inputs();
    pred_req_idx = '0;
    upd_idx = '0;
    upd_mask = '0;
    upd_dir = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset values, with requests asserted.
    @(posedge clock); #1;
    pred_req_valid = 1'b1;
    upd_valid = 1'b1;
    @(negedge clock);
    chk("rst_init_busy", init_busy, 1);
    chk("rst_pred_ready", pred_req_ready, 0);
    chk("rst_upd_ready", upd_ready, 0);
    chk("rst_mem_r_en", mem_r_en, 0);
    chk("rst_mem_w_en", mem_w_en, 0);
    chk("rst_resp_valid", pred_resp_valid, 0);
    @(posedge clock); #1;
    idle_inputs();
    reset = 1'b0;
    check_sweep("sweep0");

    // Table-driven updates and predictions, one vector per consecutive cycle.
    add(1, 5, 4'h0, 4'h0, 12'h000);
    add(1, 0, 4'h0, 4'h0, 12'h000);
    add(1, 2047, 4'h0, 4'h0, 12'h000);
    for (int k = 0; k < 3; k++) add(0, 7, 4'b0001, 4'b0001, 12'h000);
    add(1, 7, 4'h0, 4'h0, 12'h003);
    add(0, 7, 4'b0001, 4'b0001, 12'h000);
    add(1, 7, 4'h0, 4'h0, 12'h003);
    for (int k = 0; k < 5; k++) add(0, 7, 4'b0010, 4'b0000, 12'h000);
    add(1, 7, 4'h0, 4'h0, 12'h023);
    for (int k = 0; k < 3; k++) add(0, 9, 4'b1111, 4'b1111, 12'h000);
    add(1, 9, 4'h0, 4'h0, 12'h6DB);
    add(0, 2047, 4'b1111, 4'b0101, 12'h000);
    add(1, 2047, 4'h0, 4'h0, 12'hE79);
    add(1, 8, 4'h0, 4'h0, 12'h000);

    for (int v = 0; v < tbl.size(); v++) begin
      @(posedge clock); #1;
      idle_inputs();
      if (tbl[v].is_pred) begin
        pred_req_valid = 1'b1;
        pred_req_idx = tbl[v].idx;
        sb.push_back(tbl[v].exp);
      end else begin
        upd_valid = 1'b1;
        upd_idx = tbl[v].idx;
        upd_mask = tbl[v].mask;
        upd_dir = tbl[v].dir;
        model[tbl[v].idx] = sat_upd(model[tbl[v].idx], tbl[v].mask, tbl[v].dir);
      end
      @(negedge clock);
      chk($sformatf("vec%0d_accept", v), tbl[v].is_pred ? pred_req_ready : upd_ready, 1);
    end
    @(posedge clock); #1;
    idle_inputs();
    drain("table");

    // Arbitration: simultaneous requests, prediction wins, update follows.
    @(posedge clock); #1;
    pred_req_valid = 1'b1;
    pred_req_idx = 11'd9;
    upd_valid = 1'b1;
    upd_idx = 11'd11;
    upd_mask = 4'b0001;
    upd_dir = 4'b0001;
    sb.push_back(12'h6DB);
    @(negedge clock);
    chk("arb_upd_ready_low", upd_ready, 0);
    chk("arb_r_addr_pred", mem_r_addr, 9);
    @(posedge clock); #1;
    pred_req_valid = 1'b0;
    model[11] = sat_upd(model[11], 4'b0001, 4'b0001);
    @(negedge clock);
    chk("arb_resp_valid", pred_resp_valid, 1);
    chk("arb_upd_ready_high", upd_ready, 1);
    chk("arb_r_addr_upd", mem_r_addr, 11);
    @(posedge clock); #1;
    upd_valid = 1'b0;
    @(negedge clock);
    chk("arb_w_en", mem_w_en, 1);
    chk("arb_w_addr", mem_w_addr, 11);
    chk("arb_w_data", mem_w_data, 12'h001);
    drain("arb");

    // Random single-request traffic on a few indices, expected values from the model.
    for (int k = 0; k < 80; k++) begin
      op = $urandom_range(0, 2);
      ix = 11'($urandom_range(0, 3));
      rm = 4'($urandom);
      rd = 4'($urandom);
      @(posedge clock); #1;
      idle_inputs();
      if (op == 0) begin
        pred_req_valid = 1'b1;
        pred_req_idx = ix;
        sb.push_back(model[ix]);
      end else if (op == 1) begin
        upd_valid = 1'b1;
        upd_idx = ix;
        upd_mask = rm;
        upd_dir = rd;
        model[ix] = sat_upd(model[ix], rm, rd);
      end
    end
    @(posedge clock); #1;
    idle_inputs();
    drain("rand");

    // Reset with an update in S1 and a prediction presented in the reset cycle.
    @(posedge clock); #1;
    upd_valid = 1'b1;
    upd_idx = 11'd2000;
    upd_mask = 4'b1111;
    upd_dir = 4'b1111;
    @(negedge clock);
    chk("s1rst_accept", upd_ready, 1);
    @(posedge clock); #1;
    upd_valid = 1'b0;
    pred_req_valid = 1'b1;
    pred_req_idx = 11'd7;
    reset = 1'b1;
    @(negedge clock);
    chk("s1rst_w_en_dropped", mem_w_en, 0);
    chk("s1rst_pred_ready", pred_req_ready, 0);
    chk("s1rst_r_en", mem_r_en, 0);
    chk("s1rst_busy", init_busy, 1);
    @(posedge clock); #1;
    pred_req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;

    // Reset again mid-sweep at address 100.
    found = 0;
    for (int c = 0; c < 300 && found == 0; c++) begin
      @(negedge clock);
      if (mem_w_en === 1'b1 && mem_w_addr === 11'd100) found = 1;
    end
    chk("midsweep_reached_100", found, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("midsweep_rst_w_en", mem_w_en, 0);
    chk("midsweep_rst_busy", init_busy, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    check_sweep("resweep");
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Every entry reads back zero after the restarted sweep.
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clock); #1;
      pred_req_valid = 1'b1;
      pred_req_idx = i[IDX_W-1:0];
      sb.push_back(model[i]);
    end
    @(posedge clock); #1;
    idle_inputs();
    drain("readall");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
